// File: rtl/divisor_secuencial_n_if.sv
// divisor_secuencial_n_if: start/operand/result bundle for the sequential divider
interface divisor_secuencial_n_if #(parameter int WIDTH = 4);
    logic             inicio;
    logic [WIDTH-1:0] dividendo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] cociente;
    logic [WIDTH-1:0] residuo;
    logic             listo;
    logic             ocupado;
    logic             div_cero;
    modport master (output inicio, dividendo, divisor,
                    input  cociente, residuo, listo, ocupado, div_cero);
    modport slave  (input  inicio, dividendo, divisor,
                    output cociente, residuo, listo, ocupado, div_cero);
endinterface

// File: rtl/divisor_secuencial_n.sv
// divisor_secuencial_n: restoring shift-subtract unsigned divider, one quotient bit per cycle
module divisor_secuencial_n #(
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    divisor_secuencial_n_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {ESPERA, CALCULA, FIN} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] coc_q, coc_d, res_q, res_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   shf, dif;
    // dvd_q shifts the dividend out MSB first while quotient bits shift in behind it
    always_comb begin
        shf     = {rem_q, dvd_q[WIDTH-1]};
        dif     = shf - {1'b0, dvs_q};
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        coc_d   = coc_q;
        res_d   = res_q;
        dz_d    = dz_q;
        case (state_q)
            ESPERA: if (bus.inicio) begin
                dvd_d = bus.dividendo;
                dvs_d = bus.divisor;
                cnt_d = CW'(WIDTH - 1);
                rem_d = '0;
                if (bus.divisor == '0) begin
                    state_d = FIN;
                    coc_d   = '1;
                    res_d   = bus.dividendo;
                    dz_d    = 1'b1;
                end else begin
                    state_d = CALCULA;
                end
            end
            CALCULA: begin
                rem_d = dif[WIDTH] ? shf[WIDTH-1:0] : dif[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~dif[WIDTH]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIN;
                    coc_d   = dvd_d;
                    res_d   = rem_d;
                    dz_d    = 1'b0;
                end
            end
            default: state_d = ESPERA;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ESPERA;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            coc_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            coc_q   <= coc_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end
    assign bus.cociente = coc_q;
    assign bus.residuo  = res_q;
    assign bus.div_cero = dz_q;
    assign bus.listo    = state_q == FIN;
    assign bus.ocupado  = state_q != ESPERA;
endmodule

// File: tb/tb_divisor_secuencial_n.sv
// tb_divisor_secuencial_n: scoreboard-driven scenario bench for the sequential divider
module tb_divisor_secuencial_n;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   listo_cnt = 0;
    logic [2*W:0] sb_q[$];

    divisor_secuencial_n_if #(.WIDTH(W)) bus ();
    divisor_secuencial_n #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(negedge clk) if (bus.listo) listo_cnt++;

    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? {{W{1'b1}}, a, 1'b1} : {a / b, a % b, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat, output int occ);
        sb_q.push_back(model(a, b));
        bus.dividendo = a;
        bus.divisor   = b;
        bus.inicio    = 1'b1;
        step();
        bus.inicio    = 1'b0;
        bus.dividendo = W'($urandom);
        bus.divisor   = W'($urandom);
        lat = 1;
        occ = 0;
        while (!bus.listo && lat < 20) begin
            occ += int'(bus.ocupado);
            step();
            lat++;
        end
        occ += int'(bus.ocupado);
    endtask

    task automatic test_reset();
        logic [3*W+1:0] got;
        bus.inicio    = 1'b1;
        bus.dividendo = 4'd13;
        bus.divisor   = 4'd3;
        rst_n         = 1'b0;
        step();
        step();
        got = {bus.cociente, bus.residuo, bus.div_cero, bus.listo, bus.ocupado};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        bus.inicio = 1'b0;
        rst_n      = 1'b1;
        step();
        n_cmp++;
        if (bus.ocupado !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_priority: ocupado got %b expected 0", bus.ocupado);
        end
    endtask

    task automatic test_basic();
        int lat, occ;
        logic [2*W:0] exp_r, got;
        run_op(4'd13, 4'd3, lat, occ);
        n_cmp++;
        if (lat !== W + 1) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, W + 1);
        end
        n_cmp++;
        if (occ !== W + 1) begin
            n_bad++;
            $display("FAIL basic_ocupado_cycles: got %0d expected %0d", occ, W + 1);
        end
        exp_r = sb_q.pop_front();
        got   = {bus.cociente, bus.residuo, bus.div_cero};
        n_cmp++;
        if (got !== exp_r) begin
            n_bad++;
            $display("FAIL basic_result: got %h expected %h", got, exp_r);
        end
        step();
        n_cmp++;
        if ({bus.listo, bus.ocupado} !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_idle: listo/ocupado got %b expected 00", {bus.listo, bus.ocupado});
        end
    endtask

    task automatic run_table(input string tag, input logic [W-1:0] ta[], input logic [W-1:0] tb[]);
        int lat, occ, want;
        logic [2*W:0] exp_r, got;
        foreach (ta[i]) begin
            run_op(ta[i], tb[i], lat, occ);
            want = (tb[i] == '0) ? 1 : W + 1;
            n_cmp++;
            if (lat !== want) begin
                n_bad++;
                $display("FAIL %s_latency %0d/%0d: got %0d expected %0d", tag, ta[i], tb[i], lat, want);
            end
            exp_r = sb_q.pop_front();
            got   = {bus.cociente, bus.residuo, bus.div_cero};
            n_cmp++;
            if (got !== exp_r) begin
                n_bad++;
                $display("FAIL %s_result %0d/%0d: got %h expected %h", tag, ta[i], tb[i], got, exp_r);
            end
            step();
        end
    endtask

    task automatic test_div_cero();
        run_table("div_cero", '{4'd7, 4'd8}, '{4'd0, 4'd2});
    endtask

    task automatic test_boundaries();
        run_table("boundary", '{4'd15, 4'd3, 4'd0, 4'd15}, '{4'd1, 4'd9, 4'd5, 4'd15});
    endtask

    task automatic test_ignore_inicio();
        int lat, cnt0;
        logic [2*W:0] prev, exp_r, got;
        prev = model(4'd15, 4'd15);
        cnt0 = listo_cnt;
        sb_q.push_back(model(4'd13, 4'd3));
        bus.dividendo = 4'd13;
        bus.divisor   = 4'd3;
        bus.inicio    = 1'b1;
        step();
        bus.inicio = 1'b0;
        step();
        got = {bus.cociente, bus.residuo, bus.div_cero};
        n_cmp++;
        if (got !== prev) begin
            n_bad++;
            $display("FAIL hold_during_calc: got %h expected %h", got, prev);
        end
        bus.inicio    = 1'b1;
        bus.dividendo = 4'd9;
        bus.divisor   = 4'd2;
        step();
        bus.inicio    = 1'b0;
        bus.dividendo = 4'd5;
        bus.divisor   = 4'd7;
        lat = 3;
        while (!bus.listo && lat < 20) begin
            step();
            lat++;
        end
        n_cmp++;
        if (lat !== W + 1) begin
            n_bad++;
            $display("FAIL ignore_latency: got %0d expected %0d", lat, W + 1);
        end
        exp_r = sb_q.pop_front();
        got   = {bus.cociente, bus.residuo, bus.div_cero};
        n_cmp++;
        if (got !== exp_r) begin
            n_bad++;
            $display("FAIL ignore_result: got %h expected %h", got, exp_r);
        end
        step();
        step();
        n_cmp++;
        if (listo_cnt - cnt0 !== 1) begin
            n_bad++;
            $display("FAIL ignore_single_listo: got %0d pulses expected 1", listo_cnt - cnt0);
        end
    endtask

    task automatic test_reset_mid();
        int lat, occ, cnt0;
        logic [3*W+1:0] outs;
        logic [2*W:0] exp_r, got;
        bus.dividendo = 4'd13;
        bus.divisor   = 4'd3;
        bus.inicio    = 1'b1;
        step();
        bus.inicio = 1'b0;
        step();
        step();
        cnt0  = listo_cnt;
        rst_n = 1'b0;
        step();
        outs = {bus.cociente, bus.residuo, bus.div_cero, bus.listo, bus.ocupado};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        repeat (8) step();
        n_cmp++;
        if (listo_cnt !== cnt0) begin
            n_bad++;
            $display("FAIL reset_mid_no_listo: got %0d pulses expected 0", listo_cnt - cnt0);
        end
        run_op(4'd10, 4'd3, lat, occ);
        n_cmp++;
        if (lat !== W + 1) begin
            n_bad++;
            $display("FAIL reset_mid_latency: got %0d expected %0d", lat, W + 1);
        end
        exp_r = sb_q.pop_front();
        got   = {bus.cociente, bus.residuo, bus.div_cero};
        n_cmp++;
        if (got !== exp_r) begin
            n_bad++;
            $display("FAIL reset_mid_result: got %h expected %h", got, exp_r);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic [2*W:0] exp_r, got;
        int lat;
        bus.inicio = 1'b1;
        for (int k = 0; k < (1 << (2 * W)); k++) begin
            a = W'(k / (1 << W));
            b = W'(k);
            bus.dividendo = a;
            bus.divisor   = b;
            sb_q.push_back(model(a, b));
            step();
            lat = (b == '0) ? 1 : W + 1;
            repeat (lat - 1) step();
            n_cmp++;
            if (bus.listo !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_listo %0d/%0d: got %b expected 1", a, b, bus.listo);
            end
            exp_r = sb_q.pop_front();
            got   = {bus.cociente, bus.residuo, bus.div_cero};
            n_cmp++;
            if (got !== exp_r) begin
                n_bad++;
                $display("FAIL b2b_result %0d/%0d: got %h expected %h", a, b, got, exp_r);
            end
            step();
        end
        bus.inicio = 1'b0;
        step();
    endtask

    initial begin
        bus.inicio    = 1'b0;
        bus.dividendo = '0;
        bus.divisor   = '0;
        test_reset();
        test_basic();
        test_div_cero();
        test_boundaries();
        test_ignore_inicio();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/divisor_secuencial_n.md
DIVISOR_SECUENCIAL_N -- requirements
Module: divisor_secuencial_n

Interface
REQ-001 Parameter: WIDTH, default 4; operand and result bit width, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 inicio  input  1  start request; sampled only in state ESPERA.
REQ-005 dividendo  input  WIDTH  unsigned dividend; captured on accepted start.
REQ-006 divisor  input  WIDTH  unsigned divisor; captured on accepted start.
REQ-007 cociente  output  WIDTH  unsigned quotient, registered.
REQ-008 residuo  output  WIDTH  unsigned remainder, registered.
REQ-009 listo  output  1  one-cycle pulse; results valid.
REQ-010 ocupado  output  1  high while an operation is in progress (CALCULA or FIN).
REQ-011 div_cero  output  1  registered flag; last completed operation had divisor == 0.

Function
REQ-012 FSM states SHALL be ESPERA, CALCULA, FIN; encoding is free.
REQ-013 ESPERA: inicio=1 at a rising edge -> start accepted; dividendo and divisor latched internally; bit counter loaded with WIDTH-1; partial remainder cleared.
REQ-014 ESPERA -> CALCULA on accepted start with divisor != 0.
REQ-015 ESPERA -> FIN on accepted start with divisor == 0, skipping CALCULA.
REQ-016 CALCULA: restoring shift-subtract, one quotient bit per cycle, MSB first.
REQ-017 Each CALCULA cycle:
  - shift partial remainder left one bit, inserting the next dividend bit;
  - trial-subtract the latched divisor in a WIDTH+1-bit datapath;
  - non-negative result: keep the difference and set the quotient bit to 1;
  - otherwise: restore the partial remainder and set the quotient bit to 0.
REQ-018 CALCULA SHALL last exactly WIDTH cycles; after the cycle with counter == 0, next state is FIN.
REQ-019 FIN lasts exactly one cycle:
  - listo=1;
  - cociente and residuo updated with final values;
  - next state ESPERA unconditionally.
REQ-020 Latency: listo high in the (WIDTH+1)th cycle after the accepting edge for divisor != 0 (cycle 5 for WIDTH=4), and in the 1st cycle for divisor == 0.
REQ-021 divisor == 0 result: cociente = all ones, residuo = dividendo, div_cero = 1.
REQ-022 Normal result: dividendo == cociente*divisor + residuo, residuo < divisor, div_cero = 0.
REQ-023 cociente, residuo and div_cero SHALL hold their values from FIN until the next FIN or reset; they do not change during a later computation.
REQ-024 inicio in CALCULA or FIN SHALL be ignored; no restart, no operand recapture.
REQ-025 Operand input changes after the accepting edge SHALL NOT affect the result.
REQ-026 inicio held high continuously: a new operation is accepted on the first edge back in ESPERA (the cycle after FIN).
REQ-027 ocupado=0 and listo=0 in ESPERA.

Reset
REQ-028 rst_n=0 at a rising edge, in any state including mid-CALCULA, SHALL:
  - force state ESPERA;
  - zero cociente, residuo, div_cero, listo, ocupado, internal registers and counter;
  - abort any operation in progress, with no listo pulse.
REQ-029 rst_n=0 SHALL take priority over inicio in the same cycle.

Verification (WIDTH=4)
REQ-030 dividendo=13, divisor=3, inicio pulse -> ocupado=1 for 5 cycles; listo pulse in cycle 5; cociente=4, residuo=1, div_cero=0.
REQ-031 dividendo=7, divisor=0 -> listo in cycle 1; cociente=15, residuo=7, div_cero=1; the next operation 8/2 gives cociente=4, residuo=0, div_cero=0.
REQ-032 Boundaries: 15/1 -> 15 r0; 3/9 -> 0 r3; 0/5 -> 0 r0; 15/15 -> 1 r0.
REQ-033 Start 13/3, then pulse inicio with 9/2 in cycle 2 and change the operand inputs -> result stays 4 r1, and only one listo pulse occurs.
REQ-034 Start 13/3, rst_n=0 in cycle 3 -> next cycle all outputs 0 and state ESPERA, no listo; a new start with 10/3 gives 3 r1.
REQ-035 Exhaustive sweep of all 256 operand pairs, inicio held high -> every result matches REQ-021/REQ-022, with back-to-back spacing of 6 cycles (nonzero divisor).
